// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: same-cycle fetch lookup, execute-stage writeback, flush.
// Optional gshare counter indexing is enabled by defining BTB_GSHARE_EN.
module branch_target_buffer #(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 128,
    parameter int TAG_W   = 7,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_valid,
    input  logic [PC_W-1:0]  lk_pc,
    output logic             lk_hit,
    output logic             lk_taken,
    output logic [PC_W-1:0]  lk_target,
    output logic [GHR_W-1:0] lk_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             flush
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));

    if (IDX_W + TAG_W + 2 > PC_W) begin : gBadTagWidth
        $error("branch_target_buffer: IDX_W + TAG_W + 2 exceeds PC_W");
    end

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] satDec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic [ENTRIES-1:0] validQ;
    logic [TAG_W-1:0]   tagQ    [ENTRIES];
    logic [PC_W-3:0]    targetQ [ENTRIES];
    logic [CNT_W-1:0]   cntQ    [ENTRIES];

    logic [IDX_W-1:0] lkIdx, updIdx, lkCntIdx, updCntIdx;
    logic [TAG_W-1:0] lkTag, updTag;
    logic             updHit;

    assign lkIdx  = lk_pc[IDX_W+1:2];
    assign lkTag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign updIdx = upd_pc[IDX_W+1:2];
    assign updTag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BTB_GSHARE_EN
    logic [GHR_W-1:0] ghrQ;

    // Counters are hashed with history; tag/target stay at the plain index.
    assign lkCntIdx  = lkIdx ^ IDX_W'(ghrQ);
    assign updCntIdx = updIdx ^ IDX_W'(upd_ghr);
    assign lk_ghr    = ghrQ;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ghrQ <= '0;
        end else if (upd_valid) begin
            ghrQ <= GHR_W'({ghrQ, upd_taken});
        end
    end

    logic unusedBits;
    assign unusedBits = ^{lk_pc, upd_pc, upd_target[1:0]};
`else
    assign lkCntIdx  = lkIdx;
    assign updCntIdx = updIdx;
    assign lk_ghr    = '0;

    logic unusedBits;
    assign unusedBits = ^{lk_pc, upd_pc, upd_target[1:0], upd_ghr};
`endif

    assign lk_hit    = lk_valid & validQ[lkIdx] & (tagQ[lkIdx] == lkTag);
    assign lk_taken  = lk_hit & cntQ[lkCntIdx][CNT_W-1];
    assign lk_target = lk_hit ? {targetQ[lkIdx], 2'b00} : '0;

    assign updHit = validQ[updIdx] & (tagQ[updIdx] == updTag);

    // Writes: reset beats flush beats update; lookups never see same-cycle writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cntQ[i] <= CNT_WEAK_NT;
            end
        end else if (flush) begin
            validQ <= '0;
        end else if (upd_valid) begin
            if (updHit) begin
                if (upd_taken) begin
                    cntQ[updCntIdx]  <= satInc(cntQ[updCntIdx]);
                    targetQ[updIdx]  <= upd_target[PC_W-1:2];
                end else begin
                    cntQ[updCntIdx]  <= satDec(cntQ[updCntIdx]);
                end
            end else if (upd_taken) begin
                validQ[updIdx]   <= 1'b1;
                tagQ[updIdx]     <= updTag;
                cntQ[updCntIdx]  <= CNT_WEAK_T;
                targetQ[updIdx]  <= upd_target[PC_W-1:2];
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (ENTRIES=64, TAG_W=8, CNT_W=2, GHR_W=6).
// Lookup expectations are queued by the stimulus and checked by an independent monitor.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst, lk_valid, lk_hit, lk_taken, upd_valid, upd_taken, flush;
    logic [31:0] lk_pc, lk_target, upd_pc, upd_target;
    logic [5:0]  lk_ghr, upd_ghr;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [5:0]  ghr;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;

    branch_target_buffer #(
        .PC_W(32), .ENTRIES(64), .TAG_W(8), .CNT_W(2), .GHR_W(6)
    ) dut (
        .clk(clk), .rst(rst),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
        .lk_target(lk_target), .lk_ghr(lk_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_ghr(upd_ghr), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h, want %h", nm, field, act, exp);
        end
    endtask

    // Monitor: every presented lookup consumes one queued expectation.
    always @(negedge clk) begin
        if (lk_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_lookup: pc %h with no queued expectation", lk_pc);
            end else begin
                cur = expQ.pop_front();
                chk(cur.name, "hit",    32'(lk_hit),    32'(cur.hit));
                chk(cur.name, "taken",  32'(lk_taken),  32'(cur.taken));
                chk(cur.name, "target", lk_target,      cur.target);
                chk(cur.name, "ghr",    32'(lk_ghr),    32'(cur.ghr));
            end
        end
    end

    task automatic look(input logic [31:0] pc, input string nm, input logic h, input logic t,
                        input logic [31:0] tg, input logic [5:0] g);
        exp_t e;
        e.name = nm; e.hit = h; e.taken = t; e.target = tg; e.ghr = g;
        lk_valid = 1'b1;
        lk_pc    = pc;
        expQ.push_back(e);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [5:0] g);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
        upd_ghr    = g;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lk_valid = 1'b0; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_ghr = '0; flush = 1'b0;
        step();
        rst = 1'b1; look(32'h100, "reset_lookup", 0, 0, 32'h0, 6'd0); step();
        look(32'h100, "post_reset", 0, 0, 32'h0, 6'd0); step();

`ifdef BTB_GSHARE_EN
        upd(32'h100, 1, 32'h200, 6'd0); step();
        upd(32'h100, 1, 32'h200, 6'd0); step();
        upd(32'h100, 0, 32'h200, 6'd0); step();
        look(32'h100, "gs_hist", 1, 0, 32'h200, 6'd6); step();
        upd(32'h100, 1, 32'h200, 6'd13); look(32'h100, "gs_pre_update", 1, 0, 32'h200, 6'd6); step();
        look(32'h100, "gs_trained", 1, 1, 32'h200, 6'd13); step();
        rst = 1'b1; upd(32'h100, 1, 32'h200, 6'd13); step();
        look(32'h100, "gs_rst", 0, 0, 32'h0, 6'd0); step();
`else
        upd(32'h100, 1, 32'h200, 6'd0); look(32'h200, "same_cycle_other", 0, 0, 32'h0, 6'd0); step();
        look(32'h100, "alloc", 1, 1, 32'h200, 6'd0); step();
        for (int i = 0; i < 3; i++) begin
            upd(32'h100, 1, 32'h200, 6'd0); step();
        end
        look(32'h100, "sat_hi", 1, 1, 32'h200, 6'd0); step();
        upd(32'h100, 0, 32'h0, 6'd0); step();
        upd(32'h100, 0, 32'h0, 6'd0); look(32'h100, "no_bypass", 1, 1, 32'h200, 6'd0); step();
        look(32'h100, "weak_nt", 1, 0, 32'h200, 6'd0); step();
        upd(32'h100, 0, 32'h0, 6'd0); step();
        upd(32'h100, 0, 32'h0, 6'd0); step();
        look(32'h100, "sat_lo", 1, 0, 32'h200, 6'd0); step();
        upd(32'h100, 1, 32'h300, 6'd0); step();
        look(32'h100, "no_wrap", 1, 0, 32'h300, 6'd0); step();
        upd(32'h100, 1, 32'h300, 6'd0); step();
        look(32'h100, "recover", 1, 1, 32'h300, 6'd0); step();

        upd(32'h4100, 1, 32'h500, 6'd0); step();
        look(32'h100, "evicted", 0, 0, 32'h0, 6'd0); step();
        look(32'h4100, "alias_alloc", 1, 1, 32'h500, 6'd0); step();
        upd(32'h8100, 0, 32'habc, 6'd0); step();
        look(32'h4100, "nt_miss_keeps", 1, 1, 32'h500, 6'd0); step();
        look(32'h8100, "nt_miss_no_alloc", 0, 0, 32'h0, 6'd0); step();
        upd(32'h104, 1, 32'h1237, 6'd0); step();
        look(32'h104, "idx1_target", 1, 1, 32'h1234, 6'd0); step();

        flush = 1'b1; upd(32'h108, 1, 32'h40, 6'd0);
        look(32'h4100, "pre_flush", 1, 1, 32'h500, 6'd0); step();
        look(32'h4100, "flush_a", 0, 0, 32'h0, 6'd0); step();
        look(32'h104, "flush_b", 0, 0, 32'h0, 6'd0); step();
        look(32'h108, "flush_drop", 0, 0, 32'h0, 6'd0); step();

        upd(32'h100, 1, 32'h200, 6'd0); step();
        rst = 1'b1; upd(32'h100, 1, 32'h200, 6'd0);
        look(32'h100, "realloc", 1, 1, 32'h200, 6'd0); step();
        look(32'h100, "rst_clears", 0, 0, 32'h0, 6'd0); step();
`endif

        repeat (3) step();
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
